// File: rtl/countdown_timer_ctrl_if.sv
// Handshake bundle between the button/preset logic, the BCD counter cascade and
// the countdown sequencer.
interface countdown_timer_ctrl_if;
    logic        start_stop;
    logic        clear;
    logic [15:0] preset;
    logic [15:0] cnt_value;
    logic [15:0] init_value;
    logic        load_n;
    logic        decrease;
    logic        stop_condition;
    logic        alarm;
    logic [1:0]  state;

    modport master (
        output start_stop, clear, preset, cnt_value,
        input  init_value, load_n, decrease, stop_condition, alarm, state
    );

    modport slave (
        input  start_stop, clear, preset, cnt_value,
        output init_value, load_n, decrease, stop_condition, alarm, state
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Start/pause/clear sequencer for a BCD MM:SS countdown cascade.
// Define AUTO_CLEAR_EN to let DONE fall back to IDLE after ALARM_TICKS ticks.
module countdown_timer_ctrl #(
    parameter int unsigned TICK_DIV       = 100000000,
    parameter logic [15:0] DEFAULT_PRESET = 16'h0100,
    parameter int unsigned ALARM_TICKS    = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    countdown_timer_ctrl_if.slave bus
);
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] limit);
        return (d > limit) ? limit : d;
    endfunction

    function automatic logic [15:0] sanitise(input logic [15:0] v);
        return {clamp_digit(v[15:12], 4'd9), clamp_digit(v[11:8], 4'd9),
                clamp_digit(v[7:4], 4'd5), clamp_digit(v[3:0], 4'd9)};
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   init_q, init_d, preset_s;
    logic          wr_en, dec_q, dec_d, reload_p1, load_n_q, alarm_q, stop_q;
    logic          tick_due, cnt_zero;

`ifdef AUTO_CLEAR_EN
    localparam int unsigned   AW         = $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
`else
    // ALARM_TICKS only matters when auto-clear is built in.
    logic unused_alarm_ticks;
    assign unused_alarm_ticks = (ALARM_TICKS != 0);
`endif

    assign preset_s = sanitise(bus.preset);
    assign tick_due = (presc_q == PRESC_LAST);
    assign cnt_zero = (bus.cnt_value == 16'h0000);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dec_d   = 1'b0;
        wr_en   = 1'b0;
        init_d  = init_q;
`ifdef AUTO_CLEAR_EN
        alarm_cnt_d = alarm_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                init_d = preset_s;
                wr_en  = bus.clear || (preset_s != init_q);
                if (bus.start_stop && !bus.clear && (init_q != 16'h0000)) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    wr_en   = 1'b1;
                end else if (bus.start_stop) begin
                    // Prescaler holds, so a tick due now is issued right after resume.
                    state_d = PAUSE;
                end else if (cnt_zero && !dec_q) begin
                    state_d = DONE;
`ifdef AUTO_CLEAR_EN
                    presc_d     = '0;
                    alarm_cnt_d = '0;
`endif
                end else begin
                    presc_d = tick_due ? '0 : presc_q + 1'b1;
                    dec_d   = tick_due && !cnt_zero;
                end
            end
            PAUSE: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    wr_en   = 1'b1;
                end else if (bus.start_stop) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.clear || bus.start_stop) begin
                    state_d = IDLE;
                    wr_en   = 1'b1;
                end
`ifdef AUTO_CLEAR_EN
                else begin
                    presc_d = tick_due ? '0 : presc_q + 1'b1;
                    if (tick_due) begin
                        if (alarm_cnt_q == ALARM_LAST) begin
                            state_d = IDLE;
                            wr_en   = 1'b1;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 1'b1;
                        end
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Outputs are registered from next-state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            dec_q     <= 1'b0;
            init_q    <= sanitise(DEFAULT_PRESET);
            reload_p1 <= 1'b0;
            load_n_q  <= 1'b1;
            alarm_q   <= 1'b0;
            stop_q    <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            dec_q     <= dec_d;
            if (wr_en) init_q <= init_d;
            reload_p1 <= wr_en;
            load_n_q  <= !reload_p1;
            alarm_q   <= (state_d == DONE);
            stop_q    <= (state_d != RUN);
        end
    end

`ifdef AUTO_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alarm_cnt_q <= '0;
        else        alarm_cnt_q <= alarm_cnt_d;
    end
`endif

    assign bus.init_value     = init_q;
    assign bus.load_n         = load_n_q;
    assign bus.decrease       = dec_q;
    assign bus.stop_condition = stop_q;
    assign bus.alarm          = alarm_q;
    assign bus.state          = state_q;
endmodule
